// File: rtl/processor_io_pkg.sv
// Shared constants and helpers for the processor I/O conditioning blocks.
package processor_io_pkg;

   localparam int DEBOUNCE_1MS_50MHZ = 50000;
   localparam int SIM_DEBOUNCE       = 4;

   // STABLE when the synchronized level matches the accepted level, PENDING otherwise.
   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/processor_debounce_bit.sv
// One input bit: 2-flop synchronizer, polarity fix, counter debounce and
// registered press/release pulses coincident with the new clean level.
module processor_debounce_bit
   import processor_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE,
   parameter int CNT_W           = 16,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_i,
   output logic clean_o,
   output logic press_o,
   output logic release_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic             PIN_IDLE = ACTIVE_LOW;

   logic             s1_q, s2_q;
   logic             lvl;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean_q, clean_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   db_state_e        state;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: synchronizer resets to the idle pin level so lvl already equals
         // clean_q when reset lifts and no spurious pulse can fire.
         s1_q      <= PIN_IDLE;
         s2_q      <= PIN_IDLE;
         cnt_q     <= '0;
         clean_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= pin_i;
         s2_q      <= s1_q;
         cnt_q     <= cnt_d;
         clean_q   <= clean_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign lvl = s2_q ^ ACTIVE_LOW;

   always_comb begin
      // NOTE: defaults first on every combinational output, so paths that skip
      // an assignment cannot infer a latch.
      cnt_d     = '0;
      clean_d   = clean_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      state     = (lvl == clean_q) ? DB_STABLE : DB_PENDING;

      if (state == DB_PENDING) begin
         if (cnt_q == CNT_LAST) begin
            clean_d   = lvl;
            press_d   = lvl;
            release_d = ~lvl;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign clean_o   = clean_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/processor_button_debounce.sv
// Conditions raw board buttons/switches for the processor input PIO: one
// debounce slice per bit plus sticky press capture with per-bit clear.
module processor_button_debounce
   import processor_io_pkg::*;
#(
   parameter int WIDTH           = 3,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
   parameter int CNT_W           = 16,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic [WIDTH-1:0] edge_capture,
   input  logic [WIDTH-1:0] capture_clear
);

   localparam int CNT_W_MIN = clog2(DEBOUNCE_CYCLES + 1);

   generate
      if (DEBOUNCE_CYCLES < 2 || CNT_W < CNT_W_MIN) begin : g_bad_params
         $error("processor_button_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
      end
   endgenerate

   logic [WIDTH-1:0] capture_q, capture_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      processor_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_bit (
         .clk       (clk),
         .reset_n   (reset_n),
         .pin_i     (pins_in[i]),
         .clean_o   (clean_out[i]),
         .press_o   (press_pulse[i]),
         .release_o (release_pulse[i])
      );
   end

   // Set is OR-ed in after the clear so a press in the clearing cycle survives.
   always_comb begin
      capture_d = (capture_q & ~capture_clear) | press_pulse;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         capture_q <= '0;
      end else begin
         capture_q <= capture_d;
      end
   end

   assign edge_capture = capture_q;

endmodule

// File: tb/tb_processor_button_debounce.sv
// Self-checking bench: directed scenarios plus random pin activity, compared
// against a sliding-window reference model of the debounce rules.
module tb_processor_button_debounce;
   import processor_io_pkg::*;

   localparam int         W    = 3;
   localparam int         DC   = SIM_DEBOUNCE;
   localparam logic [W-1:0] IDLE = '1;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] pins_in = IDLE;
   logic [W-1:0] capture_clear = '0;
   logic [W-1:0] clean_out, press_pulse, release_pulse, edge_capture;

   int passed = 0;
   int total  = 0;

   processor_button_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (16),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pins_in       (pins_in),
      .clean_out     (clean_out),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .edge_capture  (edge_capture),
      .capture_clear (capture_clear)
   );

   always #5 clk = ~clk;

   // Reference model: a level is accepted once the last DC synchronized samples
   // all disagree with the accepted level; samples reach the window 2 edges late.
   logic [W-1:0] m_clean, m_press, m_rel, m_cap;
   logic [W-1:0] m_delay[$];
   logic [W-1:0] m_win[$];

   function automatic logic [W-1:0] model_next(input logic [W-1:0] cur,
                                                 input logic [W-1:0] win[$]);
      logic [W-1:0] nxt;
      bit           flip;
      nxt = cur;
      if (win.size() == DC) begin
         for (int b = 0; b < W; b++) begin
            flip = 1'b1;
            foreach (win[j]) begin
               if (win[j][b] == cur[b]) flip = 1'b0;
            end
            if (flip) nxt[b] = ~cur[b];
         end
      end
      return nxt;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_clean <= '0;
         m_press <= '0;
         m_rel   <= '0;
         m_cap   <= '0;
         m_delay.delete();
         m_delay.push_back('0);
         m_delay.push_back('0);
         m_win.delete();
      end else begin
         m_win.push_back(m_delay.pop_front());
         m_delay.push_back(pins_in ^ IDLE);
         if (m_win.size() > DC) void'(m_win.pop_front());
         m_clean <= model_next(m_clean, m_win);
         m_press <= model_next(m_clean, m_win) & ~m_clean;
         m_rel   <= ~model_next(m_clean, m_win) & m_clean;
         m_cap   <= (m_cap & ~capture_clear) | m_press;
      end
   end

   task automatic test_reset();
      reset_n       = 1'b0;
      pins_in       = IDLE;
      capture_clear = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if ({clean_out, press_pulse, release_pulse, edge_capture} !== 12'b0) begin
            $display("FAIL reset_idle cycle %0d: got %b required %b", i,
                     {clean_out, press_pulse, release_pulse, edge_capture}, 12'b0);
         end else passed++;
      end
   endtask

   task automatic test_press_latency();
      pins_in[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if ({clean_out[0], press_pulse[0], edge_capture[0]} !==
             {1'(i >= 5), 1'(i == 5), 1'(i >= 6)}) begin
            $display("FAIL press_latency edge k+%0d: got clean/press/cap %b required %b", i,
                     {clean_out[0], press_pulse[0], edge_capture[0]},
                     {1'(i >= 5), 1'(i == 5), 1'(i >= 6)});
         end else passed++;
      end
      total++;
      if ({clean_out, edge_capture} !== {3'b001, 3'b001}) begin
         $display("FAIL press_final: got clean/cap %b required %b",
                  {clean_out, edge_capture}, 6'b001001);
      end else passed++;
   endtask

   task automatic test_glitch();
      pins_in[1] = 1'b0;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (i == 2) pins_in[1] = 1'b1;
         total++;
         if ({clean_out[1], press_pulse[1]} !== 2'b00) begin
            $display("FAIL glitch_short cycle %0d: got clean/press %b required 00", i,
                     {clean_out[1], press_pulse[1]});
         end else passed++;
      end
      pins_in[1] = 1'b0;
      @(negedge clk);
      pins_in[1] = 1'b1;
      @(negedge clk);
      pins_in[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if ({clean_out[1], press_pulse[1]} !== {1'(i >= 5), 1'(i == 5)}) begin
            $display("FAIL glitch_bounce edge k+%0d: got clean/press %b required %b", i,
                     {clean_out[1], press_pulse[1]}, {1'(i >= 5), 1'(i == 5)});
         end else passed++;
      end
   endtask

   task automatic test_release_clear();
      pins_in[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if ({clean_out[0], release_pulse[0], press_pulse[0], edge_capture[0]} !==
             {1'(i < 5), 1'(i == 5), 1'b0, 1'b1}) begin
            $display("FAIL release edge k+%0d: got clean/rel/press/cap %b required %b", i,
                     {clean_out[0], release_pulse[0], press_pulse[0], edge_capture[0]},
                     {1'(i < 5), 1'(i == 5), 1'b0, 1'b1});
         end else passed++;
      end
      capture_clear = 3'b001;
      @(negedge clk);
      capture_clear = '0;
      total++;
      if (edge_capture !== 3'b010) begin
         $display("FAIL clear_bit0: got cap %b required %b", edge_capture, 3'b010);
      end else passed++;
      capture_clear = 3'b011;
      @(negedge clk);
      capture_clear = '0;
      total++;
      if (edge_capture !== 3'b000) begin
         $display("FAIL clear_unset_noop: got cap %b required %b", edge_capture, 3'b000);
      end else passed++;
      pins_in = IDLE;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_clear_collision();
      pins_in[2] = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if ({press_pulse[2], edge_capture[2]} !== 2'b10) begin
         $display("FAIL collide_pulse: got press/cap %b required 10",
                  {press_pulse[2], edge_capture[2]});
      end else passed++;
      capture_clear[2] = 1'b1;
      @(negedge clk);
      capture_clear[2] = 1'b0;
      total++;
      if ({press_pulse[2], edge_capture[2]} !== 2'b01) begin
         $display("FAIL collide_set_wins: got press/cap %b required 01",
                  {press_pulse[2], edge_capture[2]});
      end else passed++;
   endtask

   task automatic test_async_reset();
      pins_in[0] = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if ({clean_out, edge_capture} !== 6'b100100) begin
         $display("FAIL pre_reset: got clean/cap %b required %b",
                  {clean_out, edge_capture}, 6'b100100);
      end else passed++;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({clean_out, press_pulse, release_pulse, edge_capture} !== 12'b0) begin
         $display("FAIL async_reset: got %b required %b",
                  {clean_out, press_pulse, release_pulse, edge_capture}, 12'b0);
      end else passed++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         total++;
         if ({clean_out, press_pulse} !== {(i >= 5) ? 3'b101 : 3'b000,
                                          (i == 5) ? 3'b101 : 3'b000}) begin
            $display("FAIL post_reset edge k+%0d: got clean/press %b required %b", i,
                     {clean_out, press_pulse},
                     {(i >= 5) ? 3'b101 : 3'b000, (i == 5) ? 3'b101 : 3'b000});
         end else passed++;
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         total++;
         if ({clean_out, press_pulse, release_pulse, edge_capture} !==
             {m_clean, m_press, m_rel, m_cap}) begin
            $display("FAIL random_model cycle %0d: got %b required %b", cyc,
                     {clean_out, press_pulse, release_pulse, edge_capture},
                     {m_clean, m_press, m_rel, m_cap});
         end else passed++;
         total++;
         if ((press_pulse & release_pulse) !== 3'b000) begin
            $display("FAIL random_exclusive cycle %0d: got press&rel %b required 000", cyc,
                     press_pulse & release_pulse);
         end else passed++;
         if (hold == 0) begin
            pins_in = W'($urandom);
            hold    = $urandom_range(1, 7);
         end else begin
            hold--;
         end
         capture_clear = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      end
      capture_clear = '0;
   endtask

   task automatic test_model_directed();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({clean_out, press_pulse, release_pulse, edge_capture} !==
             {m_clean, m_press, m_rel, m_cap}) begin
            $display("FAIL model_directed cycle %0d: got %b required %b", i,
                     {clean_out, press_pulse, release_pulse, edge_capture},
                     {m_clean, m_press, m_rel, m_cap});
         end else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_glitch();
      test_model_directed();
      test_release_clear();
      test_clear_collision();
      test_async_reset();
      test_model_directed();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/processor_button_debounce.md
Name: processor_button_debounce

Overview:
- Conditions raw board push-buttons and switches before they reach the 3-bit input PIO (`in_port`) of the processor.
- Per bit, it does four things:
  - 2-flop synchronization
  - polarity normalisation (active-low buttons become 1 = pressed)
  - counter-based debounce
  - single-cycle press/release pulses, plus sticky press capture
- Sits between the FPGA pins and the PIO slave, in the same `clk` domain.

Parameters:
- WIDTH, 3, number of independent input bits.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before accepting a new level (1 ms at 50 MHz). Legal range is 2 and above.
- CNT_W, 16, counter width. Must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, when 1 each pin is inverted after synchronization.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- pins_in  input  WIDTH  raw asynchronous pin levels
- clean_out  output  WIDTH  debounced level, 1 = asserted; drives the PIO `in_port`
- press_pulse  output  WIDTH  one-cycle pulse when `clean_out` bit goes 0->1
- release_pulse  output  WIDTH  one-cycle pulse when `clean_out` bit goes 1->0
- edge_capture  output  WIDTH  sticky press flags
- capture_clear  input  WIDTH  per-bit clear of `edge_capture`, sampled on `clk`

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-count):
  - Sync flops load the inactive pin level: ~0 if ACTIVE_LOW, else 0.
  - Counters go to 0.
  - `clean_out`, `press_pulse`, `release_pulse` and `edge_capture` all go to 0.
  - No pulse may be generated by reset deassertion while pins sit at their inactive level.
- Synchronizer:
  - `s1 <= pins_in`, then `s2 <= s1`.
  - `lvl = s2 ^ {WIDTH{ACTIVE_LOW}}`.
- Debounce, per bit, two effective states (STABLE when `lvl == clean_out`, PENDING otherwise):
  - STABLE: counter <= 0.
  - PENDING and counter != DEBOUNCE_CYCLES-1: counter <= counter+1.
  - PENDING and counter == DEBOUNCE_CYCLES-1: `clean_out` <= `lvl`, counter <= 0, and the matching pulse is asserted.
  - Any single-cycle return of `lvl` to `clean_out` during PENDING resets the counter (glitch rejection).
  - Counter never wraps.
- Latency:
  - A pin change first captured into `s1` at edge k, and held, updates `clean_out` at edge k+DEBOUNCE_CYCLES+1.
  - Changes shorter than DEBOUNCE_CYCLES cycles at `lvl` never propagate.
- Pulses:
  - `press_pulse`/`release_pulse` are registered.
  - Each is high for exactly the one cycle following the edge where `clean_out` changed, i.e. coincident with the new `clean_out` value.
  - The two pulses are never simultaneously high on the same bit.
- Edge capture:
  - `edge_capture[i]` is set on `press_pulse` generation and cleared by `capture_clear[i]`.
  - If set and clear occur in the same cycle, set wins.
  - Clear of an unset bit is a no-op.
- Bits are fully independent; simultaneous activity on several bits is processed in parallel.

Decomposition:
- Package `processor_io_pkg`:
  - localparam `DEBOUNCE_1MS_50MHZ = 50000`
  - localparam `SIM_DEBOUNCE = 4`
  - function `clog2`, for deriving CNT_W checks
- Sub-module `processor_debounce_bit`:
  - Contains one bit of synchronizer, counter, level and pulses.
  - Instantiated WIDTH times via generate.
  - `edge_capture` logic stays in the top.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, pins idle 3'b111):
1. Reset release with pins 3'b111 -> `clean_out`=0, no pulses, `edge_capture`=0 for 20 cycles.
2. `pins_in[0]` driven 0 and first captured at edge k, held -> `clean_out`=3'b001 at edge k+5; `press_pulse`=3'b001 for exactly one cycle; `edge_capture`=3'b001.
3. `pins_in[1]` low for 3 cycles, then high -> `clean_out[1]` stays 0, no pulse. Bounce pattern 0,1,0,0,0,0 -> single press, 5 edges after the last 1->0 capture.
4. Bit 0 pressed, then released and held -> `release_pulse[0]` one cycle, `clean_out[0]`=0, `edge_capture[0]` stays 1 until `capture_clear[0]`=1 for one cycle, then reads 0.
5. `capture_clear[2]`=1 in the same cycle as `press_pulse[2]` -> `edge_capture[2]`=1 afterwards.
6. reset_n pulsed low while bit 0's counter=2 -> all outputs 0 immediately (asynchronously). With pin still low after release, press recognized 5 edges after the first post-reset capture.
